// File: rtl/mult_pipe_n.sv
// mult_pipe_n
//   Elastic pipelined shift-add multiplier, W x W -> 2W bits. Stage k adds the
//   partial product for multiplier bit k-1, so one operand pair is accepted per
//   clock and the product leaves after W+1 register stages. Each transaction
//   carries its own unsigned/signed mode bit down the pipe.
// Ports
//   clk        in   clock, posedge
//   rst        in   asynchronous reset, active-high
//   in_valid   in   A/B/sgn hold a transaction
//   in_ready   out  transaction accepted this cycle when in_valid is high
//   A, B       in   multiplicand, multiplier (W bits)
//   sgn        in   1 = two's-complement operands, 0 = unsigned
//   out_valid  out  P holds a completed product
//   out_ready  in   downstream consumes P this cycle
//   P          out  product (2W bits)
module mult_pipe_n #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  input  logic           sgn,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] P
);

  // Operands are only needed up to stage W-1; stage W holds just the sum.
  logic [W-1:0]   r_a   [0:W-1];
  logic [W-1:0]   r_b   [0:W-1];
  logic           r_sgn [0:W-1];
  logic [2*W-1:0] r_acc [0:W];
  logic           r_vld [0:W];

  logic           w_en;
  logic [2*W-1:0] w_term [1:W];

  // A single global enable: the whole pipe freezes while a product waits.
  assign w_en      = !r_vld[W] || out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_vld[W];
  assign P         = r_acc[W];

  // Shifted partial product for each stage. In signed mode A is sign-extended,
  // and the MSB of B carries negative weight (subtracted in the last stage).
  always_comb begin
    logic [2*W-1:0] v_ext;
    v_ext = '0;
    for (int k = 1; k <= W; k++) begin
      w_term[k] = '0;
    end
    for (int k = 1; k <= W; k++) begin
      if (r_sgn[k-1]) v_ext = {{W{r_a[k-1][W-1]}}, r_a[k-1]};
      else            v_ext = {{W{1'b0}}, r_a[k-1]};
      if (r_b[k-1][k-1]) w_term[k] = v_ext << (k - 1);
      else               w_term[k] = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < W; k++) begin
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_sgn[k] <= 1'b0;
      end
      for (int k = 0; k <= W; k++) begin
        r_acc[k] <= '0;
        r_vld[k] <= 1'b0;
      end
    end else if (w_en) begin
      r_a[0]   <= A;
      r_b[0]   <= B;
      r_sgn[0] <= sgn;
      r_acc[0] <= '0;
      r_vld[0] <= in_valid;
      for (int k = 1; k < W; k++) begin
        r_a[k]   <= r_a[k-1];
        r_b[k]   <= r_b[k-1];
        r_sgn[k] <= r_sgn[k-1];
      end
      for (int k = 1; k <= W; k++) begin
        r_vld[k] <= r_vld[k-1];
        if (r_sgn[k-1] && (k == W)) r_acc[k] <= r_acc[k-1] - w_term[k];
        else                        r_acc[k] <= r_acc[k-1] + w_term[k];
      end
    end
  end

endmodule

// File: tb/tb_mult_pipe_n.sv
module tb_mult_pipe_n;

  typedef struct {
    logic [15:0] p;
    int          acc;
    bit          lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       iv4 = 1'b0, ir4, s4 = 1'b0, ov4, or4 = 1'b1;
  logic [3:0] a4 = '0, b4 = '0;
  logic [7:0] p4;

  logic       iv8 = 1'b0, ir8, s8 = 1'b0, ov8, or8 = 1'b1;
  logic [7:0] a8 = '0, b8 = '0;
  logic [15:0] p8;

  int   cyc = 0;
  int   n_tot = 0;
  int   n_pass = 0;
  exp_t q4[$];
  exp_t q8[$];

  mult_pipe_n #(.W(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .A(a4), .B(b4),
    .sgn(s4), .out_valid(ov4), .out_ready(or4), .P(p4)
  );

  mult_pipe_n #(.W(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8),
    .sgn(s8), .out_valid(ov8), .out_ready(or8), .P(p8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input longint act, input longint exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Inputs change at negedge+1; a transaction counts as accepted on the next
  // posedge if in_ready is high just before it.
  task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic s,
                       input logic [7:0] e, input bit lat);
    exp_t x;
    @(negedge clk); #1;
    iv4 = 1'b1; a4 = a; b4 = b; s4 = s;
    #1;
    for (int i = 0; i < 64; i++) begin
      if (ir4) begin
        x.p = {8'h00, e}; x.acc = cyc + 1; x.lat = lat;
        @(posedge clk);
        q4.push_back(x);
        return;
      end
      @(negedge clk); #2;
    end
    check("send4_timeout", 0, 1);
  endtask

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [15:0] e, input bit lat);
    exp_t x;
    @(negedge clk); #1;
    iv8 = 1'b1; a8 = a; b8 = b; s8 = s;
    #1;
    for (int i = 0; i < 64; i++) begin
      if (ir8) begin
        x.p = e; x.acc = cyc + 1; x.lat = lat;
        @(posedge clk);
        q8.push_back(x);
        return;
      end
      @(negedge clk); #2;
    end
    check("send8_timeout", 0, 1);
  endtask

  task automatic idle4();
    @(negedge clk); #1;
    iv4 = 1'b0;
  endtask

  task automatic idle8();
    @(negedge clk); #1;
    iv8 = 1'b0;
  endtask

  task automatic drain4(input string nm);
    for (int i = 0; i < 200; i++) begin
      if (q4.size() == 0) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    check(nm, q4.size(), 0);
  endtask

  task automatic drain8(input string nm);
    for (int i = 0; i < 200; i++) begin
      if (q8.size() == 0) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    check(nm, q8.size(), 0);
  endtask

  // Monitors: sample at negedge+3, after the driver has settled and well
  // before the next posedge that would complete the output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #3;
      if (!rst && ov4 && or4) begin
        if (q4.size() == 0) begin
          check("unexpected_out4", 1, 0);
        end else begin
          e = q4.pop_front();
          check("p4", p4, e.p);
          if (e.lat) check("lat4", cyc - e.acc, 4);
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk); #3;
      if (!rst && ov8 && or8) begin
        if (q8.size() == 0) begin
          check("unexpected_out8", 1, 0);
        end else begin
          e = q8.pop_front();
          check("p8", p8, e.p);
          if (e.lat) check("lat8", cyc - e.acc, 8);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_tot);
    $fatal(1);
  end

  initial begin
    #2;
    check("rst_ov4", ov4, 0);
    check("rst_p4", p4, 0);
    check("rst_ov8", ov8, 0);
    check("rst_p8", p8, 0);
    check("rst_ir4", ir4, 1);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    // Unsigned back-to-back stream.
    send4(4'd9, 4'd12, 1'b0, 8'd108, 1'b1);
    send4(4'd1, 4'd1,  1'b0, 8'd1,   1'b1);
    send4(4'd8, 4'd15, 1'b0, 8'd120, 1'b1);
    idle4();
    drain4("drain_unsigned");

    // Signed cases with a mode switch right behind them.
    send4(4'hD, 4'd5,  1'b1, 8'hF1, 1'b1);
    send4(4'h8, 4'h8,  1'b1, 8'h40, 1'b1);
    send4(4'd7, 4'hF,  1'b1, 8'hF9, 1'b1);
    send4(4'hF, 4'hF,  1'b0, 8'hE1, 1'b1);
    idle4();
    drain4("drain_signed");

    // Backpressure: six in, then five stalled cycles on the second product.
    send4(4'd2,  4'd3,  1'b0, 8'd6,   1'b0);
    send4(4'd4,  4'd5,  1'b0, 8'd20,  1'b0);
    send4(4'hE,  4'd3,  1'b1, 8'hFA,  1'b0);
    send4(4'd6,  4'd7,  1'b0, 8'd42,  1'b0);
    send4(4'hF,  4'hF,  1'b1, 8'h01,  1'b0);
    send4(4'd13, 4'd11, 1'b0, 8'd143, 1'b0);
    @(negedge clk); #1;
    iv4 = 1'b0; or4 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #4;
      check("bp_in_ready", ir4, 0);
      check("bp_out_valid", ov4, 1);
      check("bp_hold_p", p4, 8'd20);
    end
    @(negedge clk); #1;
    or4 = 1'b1;
    drain4("drain_backpressure");

    // Bubble between two transactions.
    send4(4'd5, 4'd5, 1'b0, 8'd25,  1'b1);
    idle4();
    send4(4'hC, 4'd6, 1'b1, 8'hE8,  1'b1);
    idle4();
    drain4("drain_bubble");

    // Reset with the pipe full and a product on the output.
    send4(4'd1, 4'd2, 1'b0, 8'd2,  1'b0);
    send4(4'd2, 4'd2, 1'b0, 8'd4,  1'b0);
    send4(4'd3, 4'd2, 1'b0, 8'd6,  1'b0);
    send4(4'd4, 4'd2, 1'b0, 8'd8,  1'b0);
    send4(4'd5, 4'd2, 1'b0, 8'd10, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("midrst_ov4", ov4, 0);
    check("midrst_p4", p4, 0);
    q4.delete();
    #1 rst = 1'b0;
    @(negedge clk); #1;
    iv4 = 1'b0;
    repeat (10) @(negedge clk);
    send4(4'd3, 4'd3, 1'b0, 8'd9, 1'b1);
    idle4();
    drain4("drain_after_reset");

    // Wider instance.
    send8(8'hFF, 8'hFF, 1'b0, 16'd65025, 1'b1);
    send8(8'h80, 8'h80, 1'b1, 16'd16384, 1'b1);
    send8(8'h80, 8'h7F, 1'b1, 16'hC080,  1'b1);
    idle8();
    drain8("drain_w8");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
